// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline hazard definitions: FSM state encodings, event-priority
// indices and the control-bundle payload. Imported by the hazard and
// forwarding logic.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_RUN      = 2'd0;
    localparam logic [STATE_W-1:0] ST_LU_STALL = 2'd1;
    localparam logic [STATE_W-1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [STATE_W-1:0] ST_REDIRECT = 2'd3;

    // Event vector bit positions; a higher index wins.
    localparam int unsigned EV_LOAD_USE = 0;
    localparam int unsigned EV_REDIRECT = 1;
    localparam int unsigned EV_DRAM     = 2;
    localparam int unsigned EV_W        = 3;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_exe_stall;
        logic id_exe_flush;
        logic exe_mem_stall;
        logic mem_wb_flush;
        logic pc_redirect_sel;
    } hazard_ctl_t;

    localparam int unsigned CTL_W = $bits(hazard_ctl_t);

    localparam hazard_ctl_t CTL_IDLE     = hazard_ctl_t'(8'b0000_0000);
    // Freeze PC..EXE/MEM and drain a bubble into MEM/WB.
    localparam hazard_ctl_t CTL_FREEZE   = hazard_ctl_t'(8'b1101_0110);
    // Take the EXE target and squash the two younger instructions.
    localparam hazard_ctl_t CTL_REDIRECT = hazard_ctl_t'(8'b0010_1001);
    // Hold IF and ID for one cycle and insert a bubble into EXE.
    localparam hazard_ctl_t CTL_LOAD_USE = hazard_ctl_t'(8'b1100_1000);

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking precedence.
// Ports: clk, rst_n (async active-low), inc, clr, cnt[WIDTH-1:0].
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush/redirect generation from the
// current state and live hazard inputs, with DRAM-wait timeout detection and
// saturating stall/flush performance counters.
// Ports: clk, rst_n; inputs load_use_stall_flag, exe_redirect, dram_busy,
// stat_clr; combinational control outputs (pc_stall .. pc_redirect_sel);
// registered ctrl_state, stall_cycles, flush_events, wait_timeout.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_use_stall_flag,
    input  logic               exe_redirect,
    input  logic               dram_busy,
    input  logic               stat_clr,
    output logic               pc_stall,
    output logic               if_id_stall,
    output logic               if_id_flush,
    output logic               id_exe_stall,
    output logic               id_exe_flush,
    output logic               exe_mem_stall,
    output logic               mem_wb_flush,
    output logic               pc_redirect_sel,
    output logic [STATE_W-1:0] ctrl_state,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_events,
    output logic               wait_timeout
);

    localparam int unsigned       WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [EV_W-1:0]    events;
    hazard_ctl_t        ctl;
    logic [WAIT_W-1:0]  wait_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Mealy control outputs. Load-use is masked in LU_STALL
    // (one bubble per hazard) and REDIRECT (ID holds a squashed instruction).
    always_comb begin
        ctl       = CTL_IDLE;
        state_nxt = ST_RUN;
        events    = '0;

        events[EV_DRAM]     = dram_busy;
        events[EV_REDIRECT] = exe_redirect;
        events[EV_LOAD_USE] = load_use_stall_flag
                              && (state != ST_LU_STALL)
                              && (state != ST_REDIRECT);

        if (events[EV_DRAM]) begin
            ctl       = CTL_FREEZE;
            state_nxt = ST_MEM_WAIT;
        end else if (events[EV_REDIRECT]) begin
            ctl       = CTL_REDIRECT;
            state_nxt = ST_REDIRECT;
        end else if (events[EV_LOAD_USE]) begin
            ctl       = CTL_LOAD_USE;
            state_nxt = ST_LU_STALL;
        end
    end

    // DRAM wait length, saturating at MAX_WAIT and cleared when memory is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!dram_busy) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Sticky timeout: sets on the edge where wait_cnt reaches MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_timeout <= 1'b0;
        end else if (stat_clr) begin
            wait_timeout <= 1'b0;
        end else if (dram_busy && (wait_cnt >= WAIT_MAX - WAIT_W'(1))) begin
            wait_timeout <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctl.pc_stall),
        .clr   (stat_clr),
        .cnt   (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctl.pc_redirect_sel),
        .clr   (stat_clr),
        .cnt   (flush_events)
    );

    assign pc_stall        = ctl.pc_stall;
    assign if_id_stall     = ctl.if_id_stall;
    assign if_id_flush     = ctl.if_id_flush;
    assign id_exe_stall    = ctl.id_exe_stall;
    assign id_exe_flush    = ctl.id_exe_flush;
    assign exe_mem_stall   = ctl.exe_mem_stall;
    assign mem_wb_flush    = ctl.mem_wb_flush;
    assign pc_redirect_sel = ctl.pc_redirect_sel;
    assign ctrl_state      = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MAX_WAIT=16, CNT_W=4).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MAX_WAIT = 16;
    localparam int unsigned CNT_W    = 4;

    localparam logic [7:0] C_IDLE = 8'b0000_0000;
    localparam logic [7:0] C_FRZ  = 8'b1101_0110;
    localparam logic [7:0] C_RED  = 8'b0010_1001;
    localparam logic [7:0] C_LU   = 8'b1100_1000;

    logic             clk;
    logic             rst_n;
    logic             load_use_stall_flag;
    logic             exe_redirect;
    logic             dram_busy;
    logic             stat_clr;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_exe_stall;
    logic             id_exe_flush;
    logic             exe_mem_stall;
    logic             mem_wb_flush;
    logic             pc_redirect_sel;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic             wait_timeout;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .load_use_stall_flag (load_use_stall_flag),
        .exe_redirect        (exe_redirect),
        .dram_busy           (dram_busy),
        .stat_clr            (stat_clr),
        .pc_stall            (pc_stall),
        .if_id_stall         (if_id_stall),
        .if_id_flush         (if_id_flush),
        .id_exe_stall        (id_exe_stall),
        .id_exe_flush        (id_exe_flush),
        .exe_mem_stall       (exe_mem_stall),
        .mem_wb_flush        (mem_wb_flush),
        .pc_redirect_sel     (pc_redirect_sel),
        .ctrl_state          (ctrl_state),
        .stall_cycles        (stall_cycles),
        .flush_events        (flush_events),
        .wait_timeout        (wait_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       b;
        logic       r;
        logic       l;
        logic       c;
        logic [7:0] ctl;
        logic [1:0] nx;
    } vec_t;

    typedef struct {
        logic [1:0]       st;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fe;
        logic             to;
    } sb_t;

    sb_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]       m_state;
    logic [CNT_W-1:0] m_stall;
    logic [CNT_W-1:0] m_flush;
    int               m_wcnt;
    logic             m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] cur_ctl();
        return {pc_stall, if_id_stall, if_id_flush, id_exe_stall,
                id_exe_flush, exe_mem_stall, mem_wb_flush, pc_redirect_sel};
    endfunction

    // Reference control decision: {next_state, ctl}.
    function automatic logic [9:0] model_dec(input logic [1:0] st, input logic b,
                                             input logic r, input logic l);
        if (b)                            return {2'd2, C_FRZ};
        if (r)                            return {2'd3, C_RED};
        if (l && st != 2'd1 && st != 2'd3) return {2'd1, C_LU};
        return {2'd0, C_IDLE};
    endfunction

    task automatic model_reset();
        m_state = 2'd0;
        m_stall = '0;
        m_flush = '0;
        m_wcnt  = 0;
        m_to    = 1'b0;
    endtask

    // One cycle: drive at negedge, check Mealy outputs, push expected
    // registered results, then pop and compare after the rising edge.
    task automatic step(input logic b, input logic r, input logic l, input logic c,
                        input logic [7:0] exp_ctl, input logic [1:0] exp_nx,
                        input string tag);
        sb_t e;
        sb_t got;
        @(negedge clk);
        dram_busy           = b;
        exe_redirect        = r;
        load_use_stall_flag = l;
        stat_clr            = c;
        #1;
        check({tag, " ctl"}, 32'(cur_ctl()), 32'(exp_ctl));

        if (c)                                  m_stall = '0;
        else if (exp_ctl[7] && !(&m_stall))     m_stall = m_stall + CNT_W'(1);
        if (c)                                  m_flush = '0;
        else if (exp_ctl[0] && !(&m_flush))     m_flush = m_flush + CNT_W'(1);
        if (b) begin
            if (m_wcnt != int'(MAX_WAIT)) m_wcnt++;
        end else begin
            m_wcnt = 0;
        end
        if (c)                                  m_to = 1'b0;
        else if (b && m_wcnt == int'(MAX_WAIT)) m_to = 1'b1;
        m_state = exp_nx;

        e.st = m_state;
        e.sc = m_stall;
        e.fe = m_flush;
        e.to = m_to;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check({tag, " state"},        32'(ctrl_state),   32'(got.st));
            check({tag, " stall_cycles"}, 32'(stall_cycles), 32'(got.sc));
            check({tag, " flush_events"}, 32'(flush_events), 32'(got.fe));
            check({tag, " wait_timeout"}, 32'(wait_timeout), 32'(got.to));
        end
    endtask

    task automatic auto_step(input logic b, input logic r, input logic l, input logic c,
                             input string tag);
        logic [9:0] d;
        d = model_dec(m_state, b, r, l);
        step(b, r, l, c, d[7:0], d[9:8], tag);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{b:0, r:0, l:0, c:0, ctl:C_IDLE, nx:2'd0};
        vecs[1]  = '{b:0, r:0, l:1, c:0, ctl:C_LU,   nx:2'd1};
        vecs[2]  = '{b:0, r:0, l:1, c:0, ctl:C_IDLE, nx:2'd0};
        vecs[3]  = '{b:0, r:0, l:1, c:0, ctl:C_LU,   nx:2'd1};
        vecs[4]  = '{b:0, r:1, l:1, c:0, ctl:C_RED,  nx:2'd3};
        vecs[5]  = '{b:0, r:0, l:1, c:0, ctl:C_IDLE, nx:2'd0};
        vecs[6]  = '{b:0, r:1, l:0, c:0, ctl:C_RED,  nx:2'd3};
        vecs[7]  = '{b:0, r:1, l:0, c:0, ctl:C_RED,  nx:2'd3};
        vecs[8]  = '{b:1, r:1, l:1, c:0, ctl:C_FRZ,  nx:2'd2};
        vecs[9]  = '{b:1, r:0, l:0, c:0, ctl:C_FRZ,  nx:2'd2};
        vecs[10] = '{b:0, r:0, l:1, c:0, ctl:C_LU,   nx:2'd1};
        vecs[11] = '{b:0, r:0, l:0, c:0, ctl:C_IDLE, nx:2'd0};

        rst_n               = 1'b0;
        dram_busy           = 1'b0;
        exe_redirect        = 1'b0;
        load_use_stall_flag = 1'b0;
        stat_clr            = 1'b0;
        model_reset();

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("reset state",        32'(ctrl_state),   32'd0);
        check("reset stall_cycles", 32'(stall_cycles), 32'd0);
        check("reset flush_events", 32'(flush_events), 32'd0);
        check("reset wait_timeout", 32'(wait_timeout), 32'd0);
        check("reset ctl idle",     32'(cur_ctl()),    32'(C_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven state/priority walk.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].b, vecs[i].r, vecs[i].l, vecs[i].c,
                 vecs[i].ctl, vecs[i].nx, $sformatf("vec%0d", i));
        end

        // Load-use pulsed for two cycles: one bubble, one stall cycle.
        auto_step(0, 0, 0, 1, "lu clr");
        auto_step(0, 0, 1, 0, "lu c1");
        check("lu c1 pc_stall", 32'(stall_cycles), 32'd1);
        auto_step(0, 0, 1, 0, "lu c2");
        check("lu c2 stall_cycles", 32'(stall_cycles), 32'd1);
        check("lu c2 state", 32'(ctrl_state), 32'd0);

        // Redirect and load-use together: redirect wins, no stall.
        auto_step(0, 0, 0, 1, "rl clr");
        step(0, 1, 1, 0, C_RED, 2'd3, "rl");
        check("rl flush_events", 32'(flush_events), 32'd1);
        check("rl stall_cycles", 32'(stall_cycles), 32'd0);
        auto_step(0, 0, 0, 0, "rl idle");

        // DRAM busy over a pending redirect: three frozen cycles, then redirect.
        auto_step(0, 0, 0, 1, "dr clr");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, C_FRZ, 2'd2, $sformatf("dr frz%0d", i));
        step(0, 1, 0, 0, C_RED, 2'd3, "dr redirect");
        check("dr stall_cycles", 32'(stall_cycles), 32'd3);
        check("dr flush_events", 32'(flush_events), 32'd1);
        auto_step(0, 0, 0, 0, "dr idle");

        // Long DRAM wait: timeout on the 16th busy edge, counter saturates.
        auto_step(0, 0, 0, 1, "to clr");
        for (int i = 1; i <= 20; i++) begin
            auto_step(1, 0, 0, 0, $sformatf("to busy%0d", i));
            if (i == 15) check("to not yet at 15", 32'(wait_timeout), 32'd0);
            if (i == 16) check("to set at 16",     32'(wait_timeout), 32'd1);
        end
        check("sat stall_cycles 15", 32'(stall_cycles), 32'd15);
        for (int i = 0; i < 3; i++) auto_step(0, 0, 0, 0, $sformatf("to idle%0d", i));
        check("to sticky", 32'(wait_timeout), 32'd1);
        check("sat holds", 32'(stall_cycles), 32'd15);
        auto_step(1, 0, 0, 1, "clr with stall");
        check("clr beats inc", 32'(stall_cycles), 32'd0);
        check("clr timeout",   32'(wait_timeout), 32'd0);
        auto_step(0, 0, 0, 0, "post clr idle");

        // Reset in the second cycle of MEM_WAIT.
        auto_step(1, 0, 0, 0, "rst mw1");
        @(negedge clk);
        dram_busy = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst mw state",      32'(ctrl_state),   32'd0);
        check("rst mw stall_cnt",  32'(stall_cycles), 32'd0);
        check("rst mw live busy",  32'(cur_ctl()),    32'(C_FRZ));
        dram_busy = 1'b0;
        #1;
        check("rst mw idle ctl",   32'(cur_ctl()),    32'(C_IDLE));
        @(posedge clk);
        #1;
        check("rst mw held state", 32'(ctrl_state),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, C_IDLE, 2'd0, "post rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
